// File: rtl/bram_arbiter.sv
// Two-client arbiter in front of a simple dual-port BRAM: one read port and one write port,
// each with its own round-robin arbiter (fixed priority when BRAM_ARBITER_FIXED_PRIO_EN is defined).
`default_nettype none

module bram_arbiter #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,

   input  logic                  c0_req,
   input  logic                  c0_we,
   input  logic [ADDR_WIDTH-1:0] c0_addr,
   input  logic [DATA_WIDTH-1:0] c0_wdata,
   output logic                  c0_gnt,
   output logic                  c0_rvalid,
   output logic [DATA_WIDTH-1:0] c0_rdata,

   input  logic                  c1_req,
   input  logic                  c1_we,
   input  logic [ADDR_WIDTH-1:0] c1_addr,
   input  logic [DATA_WIDTH-1:0] c1_wdata,
   output logic                  c1_gnt,
   output logic                  c1_rvalid,
   output logic [DATA_WIDTH-1:0] c1_rdata,

   output logic [ADDR_WIDTH-1:0] bram_rd_addr,
   output logic [ADDR_WIDTH-1:0] bram_wr_addr,
   output logic                  bram_wr_en,
   output logic [DATA_WIDTH-1:0] bram_din,
   input  logic [DATA_WIDTH-1:0] bram_dout
);

   logic w_rd_req0, w_rd_req1, w_wr_req0, w_wr_req1;
   logic w_rd_gnt0, w_rd_gnt1, w_wr_gnt0, w_wr_gnt1;
   logic w_rd_any;
   logic w_rd_pref1, w_wr_pref1;   // 1: client 1 wins the next contention

   logic                  r_rd_valid;
   logic                  r_rd_owner;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [DATA_WIDTH-1:0] r_c0_rdata;
   logic [DATA_WIDTH-1:0] r_c1_rdata;

   assign w_rd_req0 = c0_req & ~c0_we;
   assign w_rd_req1 = c1_req & ~c1_we;
   assign w_wr_req0 = c0_req &  c0_we;
   assign w_wr_req1 = c1_req &  c1_we;

`ifdef BRAM_ARBITER_FIXED_PRIO_EN
   assign w_rd_pref1 = 1'b0;
   assign w_wr_pref1 = 1'b0;
`else
   logic r_rd_last, r_wr_last;

   // The pointer records the last contended winner; uncontended grants leave it alone.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd_last <= 1'b1;
         r_wr_last <= 1'b1;
      end else begin
         if (w_rd_req0 & w_rd_req1) r_rd_last <= w_rd_gnt1;
         if (w_wr_req0 & w_wr_req1) r_wr_last <= w_wr_gnt1;
      end
   end

   assign w_rd_pref1 = ~r_rd_last;
   assign w_wr_pref1 = ~r_wr_last;
`endif

   always_comb begin
      w_rd_gnt0 = ~reset & w_rd_req0 & (~w_rd_req1 | ~w_rd_pref1);
      w_rd_gnt1 = ~reset & w_rd_req1 & (~w_rd_req0 |  w_rd_pref1);
      w_wr_gnt0 = ~reset & w_wr_req0 & (~w_wr_req1 | ~w_wr_pref1);
      w_wr_gnt1 = ~reset & w_wr_req1 & (~w_wr_req0 |  w_wr_pref1);
      w_rd_any  = w_rd_gnt0 | w_rd_gnt1;
   end

   assign c0_gnt = w_rd_gnt0 | w_wr_gnt0;
   assign c1_gnt = w_rd_gnt1 | w_wr_gnt1;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      bram_wr_en   = w_wr_gnt0 | w_wr_gnt1;
      bram_wr_addr = '0;
      bram_din     = '0;
      if (w_wr_gnt1) begin
         bram_wr_addr = c1_addr;
         bram_din     = c1_wdata;
      end else if (w_wr_gnt0) begin
         bram_wr_addr = c0_addr;
         bram_din     = c0_wdata;
      end

      bram_rd_addr = r_rd_addr;
      if (reset)          bram_rd_addr = '0;
      else if (w_rd_gnt1) bram_rd_addr = c1_addr;
      else if (w_rd_gnt0) bram_rd_addr = c0_addr;
   end

   // NOTE: sequential state uses non-blocking assignments only; the BRAM has already
   // produced bram_dout at the mid-cycle negedge, so it is captured at the closing posedge.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd_valid <= 1'b0;
         r_rd_owner <= 1'b0;
         r_rd_addr  <= '0;
         r_c0_rdata <= '0;
         r_c1_rdata <= '0;
      end else begin
         r_rd_valid <= w_rd_any;
         r_rd_owner <= w_rd_gnt1;
         if (w_rd_any)  r_rd_addr  <= w_rd_gnt1 ? c1_addr : c0_addr;
         if (w_rd_gnt0) r_c0_rdata <= bram_dout;
         if (w_rd_gnt1) r_c1_rdata <= bram_dout;
      end
   end

   // NOTE: read outputs are masked by reset so a pulse due in the reset cycle never appears.
   assign c0_rvalid = ~reset & r_rd_valid & ~r_rd_owner;
   assign c1_rvalid = ~reset & r_rd_valid &  r_rd_owner;
   assign c0_rdata  = reset ? '0 : r_c0_rdata;
   assign c1_rdata  = reset ? '0 : r_c1_rdata;

endmodule

`default_nettype wire

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: vector table, hand sequences and a read scoreboard,
// with a write-first BRAM model that reads/writes on the negedge.
`timescale 1ns/1ps

module tb_bram_arbiter;

   localparam int AW = 6;
   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          c0_req = 0, c0_we = 0, c1_req = 0, c1_we = 0;
   logic [AW-1:0] c0_addr = '0, c1_addr = '0;
   logic [DW-1:0] c0_wdata = '0, c1_wdata = '0;
   logic          c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
   logic [DW-1:0] c0_rdata, c1_rdata;
   logic [AW-1:0] bram_rd_addr, bram_wr_addr;
   logic          bram_wr_en;
   logic [DW-1:0] bram_din;
   logic [DW-1:0] bram_dout = '0;

   always #5 clock = ~clock;

   bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clock(clock), .reset(reset),
      .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
      .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
      .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
      .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
      .bram_rd_addr(bram_rd_addr), .bram_wr_addr(bram_wr_addr),
      .bram_wr_en(bram_wr_en), .bram_din(bram_din), .bram_dout(bram_dout)
   );

   // Write-first BRAM: both ports act on the mid-cycle negedge.
   logic [DW-1:0] mem [2**AW];
   always @(negedge clock) begin
      if (bram_wr_en) mem[bram_wr_addr] <= bram_din;
      bram_dout <= (bram_wr_en && bram_wr_addr == bram_rd_addr) ? bram_din : mem[bram_rd_addr];
   end

   typedef struct {
      logic          q0, w0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          q1, w1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic          g0, g1, wen;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [AW-1:0] ra;
   } vec_t;

   typedef struct {
      logic          cl;
      logic [DW-1:0] data;
      int            due;
   } rd_t;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   rd_t           sb[$];
   logic [DW-1:0] shadow [2**AW];
   logic [DW-1:0] last0 = '0, last1 = '0;
   vec_t          tbl[10];

   function automatic vec_t mk(input logic q0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic q1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic g0, g1, wen, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic [AW-1:0] ra);
      vec_t v;
      v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.g0 = g0; v.g1 = g1; v.wen = wen; v.wa = wa; v.wd = wd; v.ra = ra;
      return v;
   endfunction

   function automatic vec_t idle(input logic [AW-1:0] ra);
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ra);
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Read-return side: the scoreboard front is due exactly one cycle after its grant.
   task automatic check_reads(input string tag);
      if (sb.size() > 0 && sb[0].due == cyc) begin
         rd_t e = sb.pop_front();
         check({tag, " c0_rvalid"}, {31'd0, c0_rvalid}, {31'd0, ~e.cl});
         check({tag, " c1_rvalid"}, {31'd0, c1_rvalid}, {31'd0, e.cl});
         if (e.cl) last1 = e.data;
         else      last0 = e.data;
      end else begin
         check({tag, " c0_rvalid idle"}, {31'd0, c0_rvalid}, 32'd0);
         check({tag, " c1_rvalid idle"}, {31'd0, c1_rvalid}, 32'd0);
      end
      check({tag, " c0_rdata"}, c0_rdata, last0);
      check({tag, " c1_rdata"}, c1_rdata, last1);
   endtask

   task automatic apply(input vec_t v, input string tag);
      @(posedge clock);
      cyc++;
      #1;
      reset   = 1'b0;
      c0_req  = v.q0; c0_we = v.w0; c0_addr = v.a0; c0_wdata = v.d0;
      c1_req  = v.q1; c1_we = v.w1; c1_addr = v.a1; c1_wdata = v.d1;
      #2;
      check_reads(tag);
      check({tag, " c0_gnt"}, {31'd0, c0_gnt}, {31'd0, v.g0});
      check({tag, " c1_gnt"}, {31'd0, c1_gnt}, {31'd0, v.g1});
      check({tag, " wr_en"}, {31'd0, bram_wr_en}, {31'd0, v.wen});
      if (v.wen) begin
         check({tag, " wr_addr"}, {26'd0, bram_wr_addr}, {26'd0, v.wa});
         check({tag, " din"}, bram_din, v.wd);
      end
      check({tag, " rd_addr"}, {26'd0, bram_rd_addr}, {26'd0, v.ra});
      // Expected model: writes land before same-cycle reads (write-first).
      if (v.g0 && v.q0 && v.w0) shadow[v.a0] = v.d0;
      if (v.g1 && v.q1 && v.w1) shadow[v.a1] = v.d1;
      if (v.g0 && v.q0 && !v.w0) sb.push_back('{cl: 1'b0, data: shadow[v.a0], due: cyc + 1});
      if (v.g1 && v.q1 && !v.w1) sb.push_back('{cl: 1'b1, data: shadow[v.a1], due: cyc + 1});
   endtask

   // One reset cycle with requests from both clients still asserted.
   task automatic rst_cycle(input string tag);
      @(posedge clock);
      cyc++;
      #1;
      reset  = 1'b1;
      c0_req = 1'b1; c0_we = 1'b0; c0_addr = 6'd7;
      c1_req = 1'b1; c1_we = 1'b1; c1_addr = 6'd9; c1_wdata = 32'hFFFF_0000;
      #2;
      check({tag, " c0_gnt"}, {31'd0, c0_gnt}, 32'd0);
      check({tag, " c1_gnt"}, {31'd0, c1_gnt}, 32'd0);
      check({tag, " wr_en"}, {31'd0, bram_wr_en}, 32'd0);
      check({tag, " c0_rvalid"}, {31'd0, c0_rvalid}, 32'd0);
      check({tag, " c1_rvalid"}, {31'd0, c1_rvalid}, 32'd0);
      check({tag, " c0_rdata"}, c0_rdata, 32'd0);
      check({tag, " c1_rdata"}, c1_rdata, 32'd0);
      check({tag, " rd_addr"}, {26'd0, bram_rd_addr}, 32'd0);
      sb.delete();
      last0 = '0;
      last1 = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit fixed_prio;
`ifdef BRAM_ARBITER_FIXED_PRIO_EN
      fixed_prio = 1'b1;
`else
      fixed_prio = 1'b0;
`endif
      tbl[0] = mk(1,1,5,32'hDEADBEEF, 1,1,6,32'h12345678, 1,0, 1,5,32'hDEADBEEF, 0);
      tbl[1] = mk(0,0,0,0,            1,1,6,32'h12345678, 0,1, 1,6,32'h12345678, 0);
      tbl[2] = mk(1,0,5,0,            0,0,0,0,            1,0, 0,0,0,            5);
      tbl[3] = mk(1,1,7,32'hA5A5A5A5, 1,0,7,0,            1,1, 1,7,32'hA5A5A5A5, 7);
      tbl[4] = mk(1,0,6,0,            1,0,5,0,            1,0, 0,0,0,            6);
      tbl[5] = mk(0,0,0,0,            1,0,5,0,            0,1, 0,0,0,            5);
      if (!fixed_prio) begin
         tbl[6] = mk(1,1,8,32'd1, 1,1,9,32'd2, 0,1, 1,9,32'd2, 5);
         tbl[7] = mk(1,1,8,32'd1, 0,0,0,0,     1,0, 1,8,32'd1, 5);
         tbl[8] = mk(1,0,8,0,     1,0,9,0,     0,1, 0,0,0,     9);
         tbl[9] = mk(1,0,8,0,     1,1,3,32'd3, 1,1, 1,3,32'd3, 8);
      end else begin
         tbl[6] = mk(1,1,8,32'd1, 1,1,9,32'd2, 1,0, 1,8,32'd1, 5);
         tbl[7] = mk(0,0,0,0,     1,1,9,32'd2, 0,1, 1,9,32'd2, 5);
         tbl[8] = mk(1,0,8,0,     1,0,9,0,     1,0, 0,0,0,     8);
         tbl[9] = mk(1,1,3,32'd3, 1,0,9,0,     1,1, 1,3,32'd3, 9);
      end

      rst_cycle("reset0");
      rst_cycle("reset1");

      for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("vec%0d", i));

      // Both clients read continuously: alternating grants (fixed priority: client 0 only).
      for (int i = 0; i < 6; i++) begin
         logic g0;
         g0 = fixed_prio ? 1'b1 : (i % 2 == 0);
         apply(mk(1,0,5,0, 1,0,6,0, g0, ~g0, 0,0,0, g0 ? 6'd5 : 6'd6), $sformatf("stream%0d", i));
      end

      // Read granted, then reset the next cycle: the pulse must vanish.
      apply(mk(1,0,7,0, 0,0,0,0, 1,0, 0,0,0, 7), "pre_rst_rd");
      rst_cycle("mid_reset");
      apply(idle(0), "post_rst_idle");
      apply(mk(1,0,7,0, 0,0,0,0, 1,0, 0,0,0, 7), "post_rst_rd0");
      apply(mk(0,0,0,0, 1,0,5,0, 0,1, 0,0,0, 5), "post_rst_rd1");
      apply(idle(5), "drain0");
      apply(idle(5), "drain1");
      check("scoreboard empty", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, BRAM address width.
REQ-002 Parameter DATA_WIDTH, default 32, BRAM data width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cN_req  input  1  client N request valid (N=0,1; one port per client).
REQ-007 cN_we  input  1  client N op: 1=write, 0=read.
REQ-008 cN_addr  input  ADDR_WIDTH  client N address.
REQ-009 cN_wdata  input  DATA_WIDTH  client N write data.
REQ-010 cN_gnt  output  1  client N request accepted this cycle (combinational).
REQ-011 cN_rvalid  output  1  client N read data valid (registered, 1-cycle pulse).
REQ-012 cN_rdata  output  DATA_WIDTH  client N read data.
REQ-013 bram_rd_addr  output  ADDR_WIDTH  to BRAM read address.
REQ-014 bram_wr_addr  output  ADDR_WIDTH  to BRAM write address.
REQ-015 bram_wr_en  output  1  to BRAM write enable.
REQ-016 bram_din  output  DATA_WIDTH  to BRAM write data.
REQ-017 bram_dout  input  DATA_WIDTH  from BRAM read data.

Function
REQ-018 Two independent arbiters SHALL run each cycle: read arbiter over {cN_req & ~cN_we}, write arbiter over {cN_req & cN_we}.
REQ-019 At most one read and one write SHALL be granted per cycle; one read plus one write from different clients SHALL both be granted.
REQ-020 Each arbiter SHALL keep a 1-bit last-winner pointer; on contention it grants the client that is not the last winner; the pointer updates only on a contended grant.
REQ-021 A request SHALL be held stable by its client until cN_gnt=1; an ungranted request drives nothing to the BRAM.
REQ-022 Granted write: bram_wr_en=1, bram_wr_addr=cN_addr, bram_din=cN_wdata in the grant cycle (combinational); bram_wr_en=0 otherwise.
REQ-023 Granted read: bram_rd_addr=cN_addr in the grant cycle; BRAM captures on the mid-cycle negedge; block registers bram_dout into cN_rdata on the next posedge and pulses cN_rvalid for exactly one cycle (latency 1).
REQ-024 bram_rd_addr SHALL hold its last granted value when no read is granted.
REQ-025 Same-cycle granted read and write to the same address SHALL return the newly written data (write-first, as the BRAM provides); no extra logic is required.
REQ-026 Back-to-back reads SHALL sustain one read per cycle; cN_rdata holds its value until the next rvalid for that client.
REQ-027 No state machine beyond the two pointers and a 1-bit read-owner/valid pipeline register SHALL exist; no request is ever dropped or reordered within a client.

Reset
REQ-028 While reset=1: both pointers=client 1 (so client 0 wins first contention), cN_rvalid=0, cN_rdata=0, bram_rd_addr=0; cN_gnt=0 and bram_wr_en=0 regardless of requests.
REQ-029 Reset asserted the cycle after a read grant SHALL suppress that cN_rvalid pulse; BRAM contents are not cleared.

Configuration
REQ-030 Macro BRAM_ARBITER_FIXED_PRIO_EN: when defined, both arbiters use fixed priority (client 0 always wins contention, pointers not implemented); when undefined, round-robin per REQ-020.

Verification
REQ-031 After reset, c0 write addr 5 data 0xDEADBEEF and c1 write addr 6 data 0x12345678 same cycle -> c0_gnt=1, c1_gnt=0; next cycle c1 granted; BRAM holds both.
REQ-032 c0 read addr 5 -> c0_gnt same cycle, c0_rvalid=1 with c0_rdata=0xDEADBEEF exactly one cycle later, c1_rvalid=0.
REQ-033 c0 write addr 7 data 0xA5A5A5A5 and c1 read addr 7 same cycle -> both granted, c1_rdata=0xA5A5A5A5 next cycle.
REQ-034 Both clients continuously read for 6 cycles -> grants alternate c0,c1,c0,c1,c0,c1 (fixed-priority build: c0 all 6, c1 none).
REQ-035 Read grant in cycle N, reset=1 in cycle N+1 -> no rvalid in N+1, all outputs at reset values; reads after reset return pre-reset BRAM contents.
